// File: rtl/btb_pkg.sv
// Branch target buffer controller -- shared definitions.
// Entry layout, target-width derivation and controller FSM states.
package btb_pkg;

  // Every table entry is one 32-bit SRAM word: {valid, tag, target}.
  localparam int ENTRY_W   = 32;
  localparam int VALID_BIT = 31;
  localparam int TAG_MSB   = 30;

  // The target field fills whatever the valid bit and the tag leave over.
  function automatic int tgt_w(input int tag_w);
    return 31 - tag_w;
  endfunction

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/btb_ctrl.sv
// Branch target buffer controller for an external dual-port SRAM macro
// (port 0 read-only, port 1 write-only, both active-low select/write).
// After reset the table is cleared one word per cycle, then lookups and
// updates run at one per cycle each.
// Build option: BTB_BYPASS_EN forwards a same-cycle, same-index update into
// the lookup response; without it such a lookup is held off for one cycle.
module btb_ctrl
  import btb_pkg::*;
#(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  // lookup channel
  input  logic               lookup_valid,
  output logic               lookup_ready,
  input  logic [31:0]        lookup_pc,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic [31:0]        resp_target,
  // update channel
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [31:0]        upd_pc,
  input  logic [31:0]        upd_target,
  input  logic               upd_inval,
  output logic               init_done,
  // SRAM port 0 (read)
  output logic               csb0,
  output logic               web0,
  output logic [INDEX_W-1:0] addr0,
  output logic [31:0]        din0,
  input  logic [31:0]        dout0,
  // SRAM port 1 (write)
  output logic               csb1,
  output logic               web1,
  output logic [INDEX_W-1:0] addr1,
  output logic [31:0]        din1
);

  localparam int TGT_W = tgt_w(TAG_W);
  localparam int HI_W  = 32 - (TGT_W + 2);
  localparam logic [INDEX_W-1:0] LAST_IDX = '1;

  state_e               state;
  logic [INDEX_W-1:0]   init_idx;

  logic                 rsp_pend;
  logic [TAG_W-1:0]     rsp_tag_q;
  logic [HI_W-1:0]      rsp_hi_q;
  logic [ENTRY_W-1:0]   rd_entry;

  // Field extraction for both request channels.
  logic [INDEX_W-1:0]   lk_idx;
  logic [TAG_W-1:0]     lk_tag;
  logic [INDEX_W-1:0]   up_idx;
  logic [TAG_W-1:0]     up_tag;
  logic [ENTRY_W-1:0]   up_entry;

  assign lk_idx   = lookup_pc[INDEX_W+1:2];
  assign lk_tag   = lookup_pc[INDEX_W+TAG_W+1:INDEX_W+2];
  assign up_idx   = upd_pc[INDEX_W+1:2];
  assign up_tag   = upd_pc[INDEX_W+TAG_W+1:INDEX_W+2];
  assign up_entry = {~upd_inval, up_tag, upd_target[TGT_W+1:2]};

  // Only a subset of the PC/target bits carry table information.
  logic unused_bits;
  assign unused_bits = ^{lookup_pc, upd_pc, upd_target};

  logic run;
  logic idx_clash;
  logic lk_acc;
  logic up_acc;
  logic init_wr;

  assign run       = (state == ST_RUN);
  assign idx_clash = upd_valid && (up_idx == lk_idx);

`ifdef BTB_BYPASS_EN
  assign lookup_ready = run;
`else
  // A same-index lookup would read the stale word; let the update win and
  // have the lookup retry on the next cycle.
  assign lookup_ready = run && !idx_clash;
`endif
  assign upd_ready = run;

  assign lk_acc = lookup_valid && lookup_ready;
  assign up_acc = upd_valid && upd_ready;

  // NOTE: the FSM sits in INIT while reset is held, so the clear writes are
  // qualified with rst_n to keep port 1 idle during reset, not just after it.
  assign init_wr = (state == ST_INIT) && rst_n;

  // Port 0: read strobe for each accepted lookup; this port never writes.
  always_comb begin
    csb0  = !lk_acc;
    web0  = 1'b1;
    addr0 = lk_acc ? lk_idx : '0;
    din0  = '0;
  end

  // Port 1: table clear during INIT, accepted updates during RUN.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    csb1  = 1'b1;
    web1  = 1'b1;
    addr1 = '0;
    din1  = '0;
    if (init_wr) begin
      csb1  = 1'b0;
      web1  = 1'b0;
      addr1 = init_idx;
    end else if (up_acc) begin
      csb1  = 1'b0;
      web1  = 1'b0;
      addr1 = up_idx;
      din1  = up_entry;
    end
  end

  // Controller FSM: sweep every address once, then run until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_idx  <= '0;
      init_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout sequential logic so every
      // flop samples pre-edge values regardless of statement order.
      case (state)
        ST_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == LAST_IDX) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: ;
        default: state <= ST_INIT;
      endcase
    end
  end

  // Lookup response stage: hold tag and PC high bits until the SRAM word
  // arrives one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pend  <= 1'b0;
      rsp_tag_q <= '0;
      rsp_hi_q  <= '0;
    end else begin
      rsp_pend <= lk_acc;
      if (lk_acc) begin
        rsp_tag_q <= lk_tag;
        rsp_hi_q  <= lookup_pc[31:TGT_W+2];
      end
    end
  end

`ifdef BTB_BYPASS_EN
  logic               byp_q;
  logic [ENTRY_W-1:0] byp_entry_q;

  // Capture an update that lands on the index being read this cycle; the
  // SRAM read returns the old word, so the response takes this copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_q       <= 1'b0;
      byp_entry_q <= '0;
    end else begin
      byp_q       <= lk_acc && up_acc && (up_idx == lk_idx);
      byp_entry_q <= up_entry;
    end
  end

  assign rd_entry = byp_q ? byp_entry_q : dout0;
`else
  assign rd_entry = dout0;
`endif

  assign resp_valid  = rsp_pend;
  assign resp_hit    = rsp_pend && rd_entry[VALID_BIT]
                       && (rd_entry[TAG_MSB:TGT_W] == rsp_tag_q);
  assign resp_target = rsp_pend ? {rsp_hi_q, rd_entry[TGT_W-1:0], 2'b00} : '0;

endmodule

// File: tb/tb_btb_ctrl.sv
// Self-checking bench for btb_ctrl with a behavioural SRAM and table model.
// Honours BTB_BYPASS_EN the same way the design does.
module tb_btb_ctrl;

  localparam int INDEX_W = 5;
  localparam int TAG_W   = 9;
  localparam int TGT_W   = 31 - TAG_W;
  localparam int DEPTH   = 1 << INDEX_W;
  localparam logic [31:0] HI_MASK = ~((32'd1 << (TGT_W + 2)) - 32'd1);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               lookup_valid, lookup_ready;
  logic [31:0]        lookup_pc;
  logic               resp_valid, resp_hit;
  logic [31:0]        resp_target;
  logic               upd_valid, upd_ready, upd_inval;
  logic [31:0]        upd_pc, upd_target;
  logic               init_done;
  logic               csb0, web0, csb1, web1;
  logic [INDEX_W-1:0] addr0, addr1;
  logic [31:0]        din0, dout0, din1;

  always #5 clk = ~clk;

  btb_ctrl #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready), .lookup_pc(lookup_pc),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_target(resp_target),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_inval(upd_inval), .init_done(init_done),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0),
    .csb1(csb1), .web1(web1), .addr1(addr1), .din1(din1)
  );

  // SRAM macro: registered read on port 0, write on port 1. Contents are
  // scrambled while reset is held so the clear sweep has real work to do.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= $urandom;
    end else begin
      if (!csb0 && web0) dout0 <= mem[addr0];
      if (!csb1 && !web1) mem[addr1] <= din1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Table model: what each index should hold, plus the expected response.
  bit          m_v   [DEPTH];
  int unsigned m_tag [DEPTH];
  int unsigned m_tgt [DEPTH];
  int          m_cyc;
  bit          m_run;
  bit          e_pend;
  bit          e_hit;
  logic [31:0] e_tgt;
  int unsigned li, lt, ui, ut, utg;
  bit          exp_lr, lk_acc;

  initial begin
    m_cyc = 0; m_run = 0; e_pend = 0; e_hit = 0; e_tgt = '0;
  end

  // Compare process: mid-cycle, inputs are stable and outputs settled.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_csb0", 32'(csb0), 32'd1);
      check("rst_csb1", 32'(csb1), 32'd1);
      check("rst_web1", 32'(web1), 32'd1);
      check("rst_addr1", 32'(addr1), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_init_done", 32'(init_done), 32'd0);
      check("rst_lookup_ready", 32'(lookup_ready), 32'd0);
      check("rst_upd_ready", 32'(upd_ready), 32'd0);
      m_cyc = 0; m_run = 0; e_pend = 0;
    end else if (!m_run) begin
      check("init_csb1", 32'(csb1), 32'd0);
      check("init_web1", 32'(web1), 32'd0);
      check("init_addr1", 32'(addr1), 32'(m_cyc));
      check("init_din1", din1, 32'd0);
      check("init_lookup_ready", 32'(lookup_ready), 32'd0);
      check("init_upd_ready", 32'(upd_ready), 32'd0);
      check("init_done_low", 32'(init_done), 32'd0);
      check("init_csb0", 32'(csb0), 32'd1);
      check("init_resp_valid", 32'(resp_valid), 32'd0);
      m_cyc++;
      if (m_cyc == DEPTH) begin
        m_run = 1;
        for (int i = 0; i < DEPTH; i++) begin
          m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
        end
      end
    end else begin
      li  = (lookup_pc >> 2) % DEPTH;
      lt  = (lookup_pc >> (INDEX_W + 2)) % (1 << TAG_W);
      ui  = (upd_pc >> 2) % DEPTH;
      ut  = (upd_pc >> (INDEX_W + 2)) % (1 << TAG_W);
      utg = (upd_target >> 2) % (1 << TGT_W);
`ifdef BTB_BYPASS_EN
      exp_lr = 1;
`else
      exp_lr = !(upd_valid && ui == li);
`endif
      check("init_done", 32'(init_done), 32'd1);
      check("upd_ready", 32'(upd_ready), 32'd1);
      check("lookup_ready", 32'(lookup_ready), 32'(exp_lr));
      check("resp_valid", 32'(resp_valid), 32'(e_pend));
      if (e_pend) begin
        check("resp_hit", 32'(resp_hit), 32'(e_hit));
        check("resp_target", resp_target, e_tgt);
      end
      lk_acc = lookup_valid && exp_lr;
      check("csb0", 32'(csb0), 32'(!lk_acc));
      check("web0", 32'(web0), 32'd1);
      check("din0", din0, 32'd0);
      if (lk_acc) check("addr0", 32'(addr0), li);
      check("csb1", 32'(csb1), 32'(!upd_valid));
      check("web1", 32'(web1), 32'(!upd_valid));
      if (upd_valid) begin
        check("addr1", 32'(addr1), ui);
        check("din1", din1, (32'(!upd_inval) << 31) | (ut << TGT_W) | utg);
        m_v[ui] = !upd_inval; m_tag[ui] = ut; m_tgt[ui] = utg;
      end
      // The update is already in the model, which is exactly what a
      // forwarded same-index lookup must see; other lookups are unaffected.
      e_pend = lk_acc;
      if (lk_acc) begin
        e_hit = m_v[li] && (m_tag[li] == lt);
        e_tgt = (lookup_pc & HI_MASK) | (m_tgt[li] << 2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lookup_valid = 1'b0;
    upd_valid    = 1'b0;
    upd_inval    = 1'b0;
  endtask

  task automatic set_lk(input logic [31:0] pc);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
  endtask

  task automatic set_up(input logic [31:0] pc, input logic [31:0] tgt, input logic inval);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_target = tgt;
    upd_inval  = inval;
  endtask

  logic [31:0] sweep_pc [8];

  initial begin
    idle();
    lookup_pc = '0; upd_pc = '0; upd_target = '0;
    sweep_pc[0] = 32'h0000_0040; sweep_pc[1] = 32'h0000_0840;
    sweep_pc[2] = 32'hABCD_0124; sweep_pc[3] = 32'h0000_0124;
    sweep_pc[4] = 32'h1234_007C; sweep_pc[5] = 32'hFFFF_FFFC;
    sweep_pc[6] = 32'h0000_0000; sweep_pc[7] = 32'h0001_0044;

    repeat (3) tick();
    check("lit_rst_csb1", 32'(csb1), 32'd1);
    check("lit_rst_init_done", 32'(init_done), 32'd0);
    rst_n = 1'b1;

    // Reset arrives asynchronously in INIT cycle 10.
    repeat (10) tick();
    check("lit_init10_addr1", 32'(addr1), 32'd10);
    check("lit_init10_csb1", 32'(csb1), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("lit_async_csb1", 32'(csb1), 32'd1);
    check("lit_async_web1", 32'(web1), 32'd1);
    check("lit_async_addr1", 32'(addr1), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("lit_restart_addr1", 32'(addr1), 32'd1);
    repeat (31) tick();
    check("lit_init_done", 32'(init_done), 32'd1);
    check("lit_run_lookup_ready", 32'(lookup_ready), 32'd1);
    check("lit_run_upd_ready", 32'(upd_ready), 32'd1);

    // Update, then lookup two cycles later.
    set_up(32'h0000_0040, 32'h0000_1000, 1'b0);
    tick(); idle(); tick();
    set_lk(32'h0000_0040);
    tick(); idle();
    check("lit_hit_valid", 32'(resp_valid), 32'd1);
    check("lit_hit", 32'(resp_hit), 32'd1);
    check("lit_hit_target", resp_target, 32'h0000_1000);

    // Same index, different tag.
    set_lk(32'h0000_0840);
    tick(); idle();
    check("lit_miss_valid", 32'(resp_valid), 32'd1);
    check("lit_miss", 32'(resp_hit), 32'd0);

    // Same-cycle update and lookup to the same index.
    set_up(32'h0000_0040, 32'h0000_2000, 1'b0);
    set_lk(32'h0000_0040);
    #1;
`ifdef BTB_BYPASS_EN
    check("lit_clash_ready", 32'(lookup_ready), 32'd1);
    tick(); idle();
`else
    check("lit_clash_ready", 32'(lookup_ready), 32'd0);
    tick();
    check("lit_clash_noresp", 32'(resp_valid), 32'd0);
    upd_valid = 1'b0;
    tick(); idle();
`endif
    check("lit_clash_hit", 32'(resp_hit), 32'd1);
    check("lit_clash_target", resp_target, 32'h0000_2000);

    // Invalidate, then lookup on the next cycle.
    set_up(32'h0000_0040, 32'h0000_0000, 1'b1);
    tick(); idle();
    set_lk(32'h0000_0040);
    tick(); idle();
    check("lit_inval_valid", 32'(resp_valid), 32'd1);
    check("lit_inval_hit", 32'(resp_hit), 32'd0);

    // Back-to-back lookups, target keeps the lookup PC's high bits.
    set_up(32'hABCD_0124, 32'h1234_5678, 1'b0);
    tick(); idle();
    set_lk(32'hABCD_0124);
    tick();
    set_lk(32'h0000_0124);
    check("lit_b2b_target0", resp_target, 32'hAB34_5678);
    tick();
    set_lk(32'h0000_0040);
    check("lit_b2b_target1", resp_target, 32'h0034_5678);
    tick(); idle();
    check("lit_b2b_miss", 32'(resp_hit), 32'd0);

    // Mixed traffic over a small PC set; the compare process judges it.
    for (int i = 0; i < 48; i++) begin
      idle();
      if (i % 3 != 2) set_lk(sweep_pc[(i * 5) % 8]);
      if (i % 2 == 0) set_up(sweep_pc[(i * 3) % 8], 32'h0100_0000 * i + 32'h44 * i, (i % 10) == 6);
      tick();
    end
    idle();
    tick();

    // Reset in RUN drops an in-flight response.
    set_lk(32'hABCD_0124);
    tick(); idle();
    check("lit_inflight_valid", 32'(resp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("lit_drop_valid", 32'(resp_valid), 32'd0);
    check("lit_drop_init_done", 32'(init_done), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (DEPTH + 3) tick();
    check("lit_reinit_done", 32'(init_done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
